cam_row_loader: RTL

//  Upstream load stage for the CAM register array. Accepts a valid/ready word stream and writes it into

---
 rtl/ap_pkg.sv | 9 +
 rtl/cam_row_loader_if.sv | 19 +
 rtl/cam_row_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ap_pkg.sv
// ap_pkg: array input_mode codes and loader state encoding shared with the AP controller
package ap_pkg;
  localparam logic [2:0] ROWXROW = 3'd1;
  localparam logic [2:0] COLXCOL = 3'd2;
  localparam logic [2:0] COPY_B  = 3'd3;
  localparam logic [2:0] COPY_R  = 3'd4;
  localparam logic [2:0] COPY_A  = 3'd5;
  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} loader_state_t;
endpackage

// File: rtl/cam_row_loader_if.sv
// cam_row_loader_if: upstream word stream plus CAM array write port
interface cam_row_loader_if #(
  parameter int DATA_WIDTH = 4,
  parameter int DATA_DEPTH = 4,
  parameter int ADDR_WIDTH_CAM = 8
);
  localparam int IN_W = DATA_WIDTH > DATA_DEPTH ? DATA_WIDTH : DATA_DEPTH;
  logic [IN_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [2:0] input_mode;
  logic [ADDR_WIDTH_CAM-1:0] addr_input_Row;
  logic [ADDR_WIDTH_CAM-1:0] addr_input_Col;
  logic [DATA_WIDTH-1:0] Ip_row;
  logic [DATA_DEPTH-1:0] Ip_col;
  logic rstIn;
  modport master (output in_data, in_valid, input in_ready, input_mode, addr_input_Row, addr_input_Col, Ip_row, Ip_col, rstIn);
  modport slave (input in_data, in_valid, output in_ready, input_mode, addr_input_Row, addr_input_Col, Ip_row, Ip_col, rstIn);
endinterface

// File: rtl/cam_row_loader.sv
// cam_row_loader: loads a word stream into consecutive CAM rows/columns; CAM_LOADER_ZERO_FILL_EN zero-fills up to the last entry
module cam_row_loader
  import ap_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int DATA_DEPTH = 4,
  parameter int ADDR_WIDTH_CAM = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic col_mode,
  input  logic [ADDR_WIDTH_CAM-1:0] base_addr,
  input  logic [ADDR_WIDTH_CAM-1:0] count,
  input  logic abort,
  cam_row_loader_if.slave bus,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int IN_W = DATA_WIDTH > DATA_DEPTH ? DATA_WIDTH : DATA_DEPTH;
  localparam logic [ADDR_WIDTH_CAM:0] LIM_ROW = (ADDR_WIDTH_CAM+1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH_CAM:0] LIM_COL = (ADDR_WIDTH_CAM+1)'(DATA_WIDTH);
  localparam logic [ADDR_WIDTH_CAM-1:0] ONE = ADDR_WIDTH_CAM'(1);
  loader_state_t state;
  logic mode_col;
  logic [ADDR_WIDTH_CAM-1:0] cur, rem;
  logic hs, fill_wr, wr;
  logic [ADDR_WIDTH_CAM:0] lim, end_addr;
  logic [IN_W-1:0] wdata;
  // handshake, range limit and the write source (stream word or fill zero)
  always_comb begin
    hs = bus.in_valid & bus.in_ready & ~abort;
    lim = (state == IDLE ? col_mode : mode_col) ? LIM_COL : LIM_ROW;
    end_addr = {1'b0, base_addr} + {1'b0, count};
`ifdef CAM_LOADER_ZERO_FILL_EN
    fill_wr = (state == FILL || (state == LOAD && rem == '0)) && !abort && ({1'b0, cur} < lim);
`else
    fill_wr = 1'b0;
`endif
    wr = hs | fill_wr;
    wdata = fill_wr ? '0 : bus.in_data;
  end
  // load FSM; every array-side output is registered one cycle behind its handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode_col <= 1'b0;
      cur <= '0;
      rem <= '0;
      bus.in_ready <= 1'b0;
      bus.rstIn <= 1'b1;
      bus.input_mode <= 3'd0;
      bus.addr_input_Row <= '0;
      bus.addr_input_Col <= '0;
      bus.Ip_row <= '0;
      bus.Ip_col <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_col <= col_mode;
          cur <= base_addr;
          rem <= count;
          if (count == '0 || end_addr > lim) begin
            state <= DONE;
            done <= 1'b1;
            err <= count != '0;
          end else begin
            state <= LOAD;
            busy <= 1'b1;
            bus.in_ready <= 1'b1;
            bus.input_mode <= col_mode ? COLXCOL : ROWXROW;
          end
        end
        LOAD, FILL: begin
          bus.rstIn <= ~wr;
          if (wr) begin
            cur <= cur + ONE;
            if (mode_col) begin
              bus.addr_input_Col <= cur;
              bus.Ip_col <= wdata[DATA_DEPTH-1:0];
            end else begin
              bus.addr_input_Row <= cur;
              bus.Ip_row <= wdata[DATA_WIDTH-1:0];
            end
          end
          if (hs) begin
            rem <= rem - ONE;
            bus.in_ready <= rem != ONE;
          end
          if (abort) begin
            state <= DONE;
            bus.in_ready <= 1'b0;
            done <= 1'b1;
            err <= 1'b1;
          end else if (rem == '0) begin
            state <= fill_wr ? FILL : DONE;
            done <= !fill_wr;
          end
        end
        DONE: begin
          state <= IDLE;
          bus.rstIn <= 1'b1;
          bus.input_mode <= 3'd0;
          bus.addr_input_Row <= '0;
          bus.addr_input_Col <= '0;
          bus.Ip_row <= '0;
          bus.Ip_col <= '0;
          busy <= 1'b0;
          done <= 1'b0;
          err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
